// File: rtl/uart_tx_seq_pkg.sv
// Shared types and constants for the buffered uartTx front end.
package uart_tx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        GAP   = 2'd2,
        WRITE = 2'd3
    } tx_state_t;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int STAT_DONE      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(input logic done, input logic full,
                                                input logic ovf, input logic [15:0] count);
        logic [31:0] status;
        status                         = '0;
        status[STAT_DONE]              = done;
        status[STAT_FULL]              = full;
        status[STAT_OVF]               = ovf;
        status[STAT_COUNT_LSB +: 16]   = count;
        return status;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_byte_fifo.sv
// Byte-wide synchronous FIFO with flush; a pop frees space for a push in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty/count gate every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// CPU-facing byte queue that drains itself into uartTx, polling its status before every byte.
module uart_tx_sequencer
    import uart_tx_seq_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] TX_ADDR    = 32'hffff0040,
    parameter int          POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tx_enable,
    output logic        tx_mem_valid,
    output logic [3:0]  tx_mem_wstrb,
    output logic [31:0] tx_mem_wdata,
    output logic [31:0] tx_mem_addr,
    input  logic        tx_mem_ready,
    input  logic [31:0] tx_mem_rdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    tx_state_t     state;
    logic [GW-1:0] gap_cnt;
    logic          overflow;
    logic          flush_seen;

    logic          accept;
    logic          is_write;
    logic          status_read;
    logic          push;
    logic          pop;
    logic          flush;
    logic          all_done;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign unused_bits = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8],
                           tx_mem_rdata[31:1]};

    assign accept      = enable & mem_valid & ~mem_ready;
    assign is_write    = |mem_wstrb;
    assign status_read = accept & ~is_write & (mem_addr[2] == REG_DATA);
    assign push        = accept & is_write & (mem_addr[2] == REG_DATA);
    assign flush       = accept & is_write & (mem_addr[2] == REG_CTRL) & mem_wdata[0];
    assign pop         = (state == WRITE) & tx_mem_valid & tx_mem_ready & ~flush_seen & ~flush;
    assign all_done    = fifo_empty & (state == IDLE);

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A push is only lost when the FIFO is full and no pop frees a slot that cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            overflow  <= 1'b0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= '0;
            if (status_read)
                mem_rdata <= pack_status(all_done, fifo_full, overflow, 16'(fifo_count));
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (status_read)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            flush_seen   <= 1'b0;
            tx_enable    <= 1'b0;
            tx_mem_valid <= 1'b0;
            tx_mem_wstrb <= 4'h0;
            tx_mem_wdata <= '0;
            tx_mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        state        <= POLL;
                        tx_enable    <= 1'b1;
                        tx_mem_valid <= 1'b1;
                        tx_mem_wstrb <= 4'h0;
                        tx_mem_addr  <= TX_ADDR;
                    end
                end
                POLL: begin
                    if (tx_mem_ready) begin
                        tx_enable    <= 1'b0;
                        tx_mem_valid <= 1'b0;
                        tx_mem_addr  <= '0;
                        if (!tx_mem_rdata[0]) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else if (fifo_empty || flush) begin
                            state <= IDLE;
                        end else begin
                            // Byte is captured here so a later flush cannot change what is sent.
                            state        <= WRITE;
                            tx_mem_wdata <= {24'b0, fifo_dout};
                            flush_seen   <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state        <= POLL;
                        tx_enable    <= 1'b1;
                        tx_mem_valid <= 1'b1;
                        tx_mem_wstrb <= 4'h0;
                        tx_mem_addr  <= TX_ADDR;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (flush) flush_seen <= 1'b1;
                    if (!tx_mem_valid) begin
                        tx_enable    <= 1'b1;
                        tx_mem_valid <= 1'b1;
                        tx_mem_wstrb <= 4'hf;
                        tx_mem_addr  <= TX_ADDR;
                    end else if (tx_mem_ready) begin
                        state        <= IDLE;
                        tx_enable    <= 1'b0;
                        tx_mem_valid <= 1'b0;
                        tx_mem_wstrb <= 4'h0;
                        tx_mem_wdata <= '0;
                        tx_mem_addr  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
